captura_operandos: RTL
======================

CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 16: consecutive stable cycles needed to accept a button level change; legal range 1..2^20.
REQ-002 clk  input  1  single clock for the block; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-004 chaves  input  4  operand value from the board switches; treated as quasi-static and not synchronized.
REQ-005 botao_confirma  input  1  raw, asynchronous, active-high confirm button.
REQ-006 botao_cancela  input  1  raw, asynchronous, active-high cancel button.
REQ-007 consumido  input  1  downstream acknowledge; active-high, one or more cycles.
REQ-008 A  output  4  registered minuend operand.
REQ-009 B  output  4  registered subtrahend operand.
REQ-010 valido  output  1  high while A and B form a complete, unconsumed operand pair.
REQ-011 estado  output  2  current FSM state encoding, for the board LEDs.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each button SHALL have an independent debounce counter, cleared whenever the synchronized sample equals that button's debounced level.
REQ-014 Each debounce counter SHALL increment while the synchronized sample differs from the debounced level.
REQ-015 When a debounce counter reaches DEBOUNCE_CICLOS, the debounced level SHALL toggle and the counter SHALL clear in the same cycle.
REQ-016 A 0->1 transition of a debounced level SHALL produce exactly one single-cycle internal pulse (confirma_p or cancela_p) in the following cycle; a 1->0 transition SHALL produce no pulse.
REQ-017 From raw button high, held stable and first sampled at edge N, the FSM SHALL act at edge N+DEBOUNCE_CICLOS+3.
REQ-018 Glitches shorter than DEBOUNCE_CICLOS cycles (after synchronization) SHALL produce no pulse.
REQ-019 FSM states and encodings SHALL be ESPERA_A=2'b00, ESPERA_B=2'b01 and PRONTO=2'b10; 2'b11 is illegal and SHALL return to ESPERA_A on the next edge.
REQ-020 In ESPERA_A, confirma_p SHALL load A<=chaves and move the FSM to ESPERA_B.
REQ-021 In ESPERA_B, confirma_p SHALL load B<=chaves, move the FSM to PRONTO and set valido=1 on the same edge.
REQ-022 In PRONTO, valido SHALL stay high and A and B SHALL hold until consumido is sampled high.
REQ-023 When consumido is sampled high in PRONTO, the next edge SHALL give valido=0 and state ESPERA_A, and A and B SHALL keep their values.
REQ-024 confirma_p received in PRONTO SHALL be ignored.
REQ-025 consumido SHALL be ignored outside PRONTO.
REQ-026 cancela_p in any state SHALL force ESPERA_A and valido=0, and SHALL leave A and B unchanged.
REQ-027 If cancela_p and confirma_p occur in the same cycle, cancela_p SHALL win.
REQ-028 If cancela_p and consumido occur in the same cycle, the result SHALL be the same: state ESPERA_A and valido=0.
REQ-029 The estado output SHALL equal the state register, and valido SHALL be a register, not decoded combinationally.

Reset
REQ-030 While rst_n=0 at an edge, the FSM SHALL go to ESPERA_A and A, B, valido, synchronizer flops, debounced levels and counters SHALL all clear to 0.
REQ-031 Reset asserted mid-operation (any state, any counter value) SHALL take effect on that edge, with no partial load of A or B.
REQ-032 A button held high across reset release SHALL be treated as a new press: one pulse after debounce.

Verification
REQ-033 Bench SHALL cover: DEBOUNCE_CICLOS=4; chaves=4'h9, press confirma 10 cycles, release; chaves=4'h3, press confirma; then -> A=4'h9, B=4'h3, valido=1, estado=2'b10, first state change exactly 7 edges after the first press sample.
REQ-034 Bench SHALL cover: confirma pulsed high for 3 cycles with DEBOUNCE_CICLOS=4 -> no state change, estado=2'b00.
REQ-035 Bench SHALL cover: in PRONTO, consumido high for 1 cycle -> valido=0 and estado=2'b00 next edge, A and B unchanged; a further confirma press in PRONTO before that -> no effect.
REQ-036 Bench SHALL cover: in ESPERA_B, cancela and confirma pressed simultaneously -> estado=2'b00, B unchanged, valido=0.
REQ-037 Bench SHALL cover: rst_n=0 for 1 cycle while in PRONTO with A=4'hF, B=4'h1 -> A=0, B=0, valido=0 and estado=2'b00 on that edge.
REQ-038 Bench SHALL cover: estado forced to 2'b11 -> 2'b00 next edge.

Source files
------------

// File: rtl/captura_operandos.sv
// captura_operandos: captures two 4-bit operands (A, then B) from the board
// switches using a debounced confirm button, with a debounced cancel button
// and a downstream acknowledge.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   chaves[3:0]    switch value, quasi-static
//   botao_confirma raw asynchronous confirm button (active high)
//   botao_cancela  raw asynchronous cancel button (active high)
//   consumido      downstream acknowledge, honoured only in PRONTO
//   A[3:0], B[3:0] captured operands
//   valido         registered "A and B form a complete unconsumed pair"
//   estado[1:0]    FSM state register, for LEDs

package captura_operandos_pkg;
    typedef enum logic [1:0] {
        ESPERA_A = 2'b00,
        ESPERA_B = 2'b01,
        PRONTO   = 2'b10
    } estado_t;
endpackage

// Per-button synchronizer + debouncer + rising-edge pulse.
// Latency from first raw-high sample to pulse visible at the FSM input:
// 2 sync flops, DEBOUNCE_CICLOS counting edges, 1 registered pulse.
module captura_operandos_debounce #(
    parameter int unsigned DEBOUNCE_CICLOS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_botao,
    output logic o_pulso
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
    // Toggle on the edge where the count would reach DEBOUNCE_CICLOS.
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

    logic          r_sinc1;
    logic          r_sinc2;
    logic          r_nivel;
    logic          r_nivel_ant;
    logic          r_pulso;
    logic [CW-1:0] r_cont;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sinc1     <= 1'b0;
            r_sinc2     <= 1'b0;
            r_nivel     <= 1'b0;
            r_nivel_ant <= 1'b0;
            r_pulso     <= 1'b0;
            r_cont      <= '0;
        end else begin
            r_sinc1     <= i_botao;
            r_sinc2     <= r_sinc1;
            r_nivel_ant <= r_nivel;
            // Only a 0->1 debounced transition produces a pulse.
            r_pulso     <= r_nivel & ~r_nivel_ant;
            if (r_sinc2 == r_nivel) begin
                r_cont <= '0;
            end else if (r_cont == LIMITE) begin
                r_nivel <= ~r_nivel;
                r_cont  <= '0;
            end else begin
                r_cont <= r_cont + CW'(1);
            end
        end
    end

    assign o_pulso = r_pulso;
endmodule

module captura_operandos
    import captura_operandos_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] chaves,
    input  logic       botao_confirma,
    input  logic       botao_cancela,
    input  logic       consumido,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       valido,
    output logic [1:0] estado
);
    // Bit 0 = confirm, bit 1 = cancel.
    logic [1:0] w_botoes;
    logic [1:0] w_pulsos;
    logic       w_confirma_p;
    logic       w_cancela_p;

    assign w_botoes = {botao_cancela, botao_confirma};

    for (genvar i = 0; i < 2; i++) begin : gen_botao
        captura_operandos_debounce #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_botao(w_botoes[i]),
            .o_pulso(w_pulsos[i])
        );
    end

    assign w_confirma_p = w_pulsos[0];
    assign w_cancela_p  = w_pulsos[1];

    estado_t    r_estado;
    estado_t    w_prox;
    logic [3:0] r_A;
    logic [3:0] r_B;
    logic       r_valido;
    logic       w_carrega_a;
    logic       w_carrega_b;
    logic       w_valido_prox;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= ESPERA_A;
            r_A      <= 4'h0;
            r_B      <= 4'h0;
            r_valido <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_valido <= w_valido_prox;
            if (w_carrega_a) r_A <= chaves;
            if (w_carrega_b) r_B <= chaves;
        end
    end

    always_comb begin
        w_prox      = r_estado;
        w_carrega_a = 1'b0;
        w_carrega_b = 1'b0;
        if (w_cancela_p) begin
            // Cancel dominates confirm and consumido; operands untouched.
            w_prox = ESPERA_A;
        end else begin
            case (r_estado)
                ESPERA_A: if (w_confirma_p) begin
                    w_carrega_a = 1'b1;
                    w_prox      = ESPERA_B;
                end
                ESPERA_B: if (w_confirma_p) begin
                    w_carrega_b = 1'b1;
                    w_prox      = PRONTO;
                end
                PRONTO:   if (consumido) w_prox = ESPERA_A;
                default:  w_prox = ESPERA_A;
            endcase
        end
        // valido is registered and tracks entry into / exit from PRONTO.
        w_valido_prox = (w_prox == PRONTO);
    end

    assign A      = r_A;
    assign B      = r_B;
    assign valido = r_valido;
    assign estado = r_estado;
endmodule
